// File: rtl/bench_controller_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : bench_controller_if
// Purpose  : Bundles the bench_controller run-control and status signals.
//            The master side is the workbench/checker and the slave side is
//            the controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface bench_controller_if #(
   parameter int NUM_CORES = 2,
   parameter int PC_W      = 32,
   parameter int CNT_W     = 32
);
   logic                      start;
   logic [NUM_CORES*PC_W-1:0] pc_flat;
   logic [NUM_CORES*PC_W-1:0] end_pc_flat;
   logic                      run;
   logic [NUM_CORES-1:0]      halted;
   logic                      done;
   logic                      timeout;
   logic                      pass;
   logic [CNT_W-1:0]          cycle_count;

   modport master (
      output start, pc_flat, end_pc_flat,
      input  run, halted, done, timeout, pass, cycle_count
   );

   modport slave (
      input  start, pc_flat, end_pc_flat,
      output run, halted, done, timeout, pass, cycle_count
   );
endinterface
`default_nettype wire

// File: rtl/bench_controller.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : bench_controller
// Purpose  : Multi-core bench harness controller. Gates all cores with a
//            common run enable, detects per-core halt as a PC that is stable
//            for HALT_CYCLES samples, enforces a global cycle timeout and
//            reports done/timeout/pass against per-core expected end PCs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module bench_controller #(
   parameter int NUM_CORES   = 2,
   parameter int PC_W        = 32,
   parameter int HALT_CYCLES = 4,
   parameter int MAX_CYCLES  = 1000,
   parameter int CNT_W       = 32
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   bench_controller_if.slave bus
);

   localparam int                ST_W       = $clog2(HALT_CYCLES + 1);
   localparam logic [ST_W-1:0]   c_HALT     = ST_W'(HALT_CYCLES);
   localparam logic [ST_W-1:0]   c_HALT_M1  = ST_W'(HALT_CYCLES - 1);
   localparam logic [ST_W-1:0]   c_ONE      = ST_W'(1);
   localparam logic [CNT_W-1:0]  c_MAX      = CNT_W'(MAX_CYCLES);
   localparam logic [CNT_W-1:0]  c_CNT_SAT  = '1;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_DONE    = 2'd2,
      S_TIMEOUT = 2'd3
   } state_t;

   state_t               r_state;
   logic                 r_run;
   logic                 r_done;
   logic                 r_timeout;
   logic                 r_pass;
   logic [NUM_CORES-1:0] r_halted;
   logic [NUM_CORES-1:0] r_valid;
   logic [CNT_W-1:0]     r_cycle_count;
   logic [PC_W-1:0]      r_last_pc [NUM_CORES];
   logic [ST_W-1:0]      r_stable  [NUM_CORES];

   logic [NUM_CORES-1:0] w_end_match;
   logic                 w_all_halted;

   // Per-core comparison of the held PC against the expected end PC
   generate
      for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
         assign w_end_match[g] = (r_last_pc[g] == bus.end_pc_flat[g*PC_W +: PC_W]);
      end
   endgenerate

   assign w_all_halted = &r_halted;

   // Run-control FSM with per-core halt detection; all outputs registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_run         <= 1'b0;
         r_done        <= 1'b0;
         r_timeout     <= 1'b0;
         r_pass        <= 1'b0;
         r_halted      <= '0;
         r_valid       <= '0;
         r_cycle_count <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            r_last_pc[i] <= '0;
            r_stable[i]  <= '0;
         end
      end else if (r_state != S_RUN) begin
         // IDLE, DONE and TIMEOUT all hold until start launches a fresh run
         if (bus.start) begin
            r_state       <= S_RUN;
            r_run         <= 1'b1;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
            r_pass        <= 1'b0;
            r_halted      <= '0;
            r_valid       <= '0;
            r_cycle_count <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
               r_stable[i] <= '0;
            end
         end
      end else begin
         // All-halted takes priority over the limit so a run that halts on
         // the final allowed cycle still reports a normal finish.
         if (w_all_halted) begin
            r_state <= S_DONE;
            r_run   <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= &w_end_match;
         end else if (r_cycle_count == c_MAX) begin
            r_state   <= S_TIMEOUT;
            r_run     <= 1'b0;
            r_done    <= 1'b1;
            r_timeout <= 1'b1;
            r_pass    <= 1'b0;
         end else begin
            if (r_cycle_count != c_CNT_SAT) begin
               r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
            // A halted core is frozen so its halt PC is what gets judged
            for (int i = 0; i < NUM_CORES; i++) begin
               if (!r_halted[i]) begin
                  if (!r_valid[i]) begin
                     r_valid[i]   <= 1'b1;
                     r_last_pc[i] <= bus.pc_flat[i*PC_W +: PC_W];
                     r_stable[i]  <= c_ONE;
                  end else if (bus.pc_flat[i*PC_W +: PC_W] == r_last_pc[i]) begin
                     if (r_stable[i] != c_HALT) begin
                        r_stable[i] <= r_stable[i] + c_ONE;
                     end
                     if (r_stable[i] == c_HALT_M1) begin
                        r_halted[i] <= 1'b1;
                     end
                  end else begin
                     r_stable[i]  <= c_ONE;
                     r_last_pc[i] <= bus.pc_flat[i*PC_W +: PC_W];
                  end
               end
            end
         end
      end
   end

   assign bus.run         = r_run;
   assign bus.halted      = r_halted;
   assign bus.done        = r_done;
   assign bus.timeout     = r_timeout;
   assign bus.pass        = r_pass;
   assign bus.cycle_count = r_cycle_count;

endmodule
`default_nettype wire
